// File: rtl/ptcalc_mac_pkg.sv
// Shared types, default widths and saturation bounds for the ptcalc MAC round/saturate stage.
// Build option: PTCALC_MAC_ROUND_EN selects round-half-up instead of floor in the core.
package ptcalc_mac_pkg;

    localparam int PROD_W_DEF    = 38;
    localparam int MAX_TERMS_DEF = 8;
    localparam int ACC_W_DEF     = 44;
    localparam int SHIFT_DEF     = 12;
    localparam int OUT_W_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/ptcalc_mac_rndsat_core.sv
// Combinational round/shift/clip of the accumulator into the signed pT word.
// Build option: PTCALC_MAC_ROUND_EN adds half an LSB before the shift (round half up).
module ptcalc_mac_rndsat_core
    import ptcalc_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] pt,
    output logic             sat
);

    localparam logic signed [63:0] HI = sat_max(OUT_W);
    localparam logic signed [63:0] LO = sat_min(OUT_W);

    // One guard bit above the accumulator so the rounding bias can never wrap.
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    logic signed [63:0]    r64;

`ifdef PTCALC_MAC_ROUND_EN
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
`endif

    always_comb begin
        wide = {acc[ACC_W-1], acc};
`ifdef PTCALC_MAC_ROUND_EN
        biased = wide + HALF;
`else
        biased = wide;
`endif
        shifted = biased >>> SHIFT;
        r64     = {{(63 - ACC_W){shifted[ACC_W]}}, shifted};
        pt      = r64[OUT_W-1:0];
        sat     = 1'b0;
        if (r64 > HI) begin
            pt  = HI[OUT_W-1:0];
            sat = 1'b1;
        end else if (r64 < LO) begin
            pt  = LO[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/ptcalc_mac_rndsat.sv
// Burst accumulator for ptcalc products: sums one burst, then rounds/shifts/saturates to a signed pT word.
// Build option: PTCALC_MAC_ROUND_EN (round half up); undefined = floor.
module ptcalc_mac_rndsat
    import ptcalc_mac_pkg::*;
#(
    parameter  int PROD_W    = PROD_W_DEF,
    parameter  int MAX_TERMS = MAX_TERMS_DEF,
    parameter  int ACC_W     = ACC_W_DEF,
    parameter  int SHIFT     = SHIFT_DEF,
    parameter  int OUT_W     = OUT_W_DEF,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              prod_vld,
    output logic              prod_rdy,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_first,
    input  logic              prod_last,
    output logic              pt_vld,
    input  logic              pt_rdy,
    output logic [OUT_W-1:0]  pt_data,
    output logic              pt_sat,
    output logic [CNT_W-1:0]  pt_nterms
);

    if (ACC_W < PROD_W + $clog2(MAX_TERMS) + 1) begin : g_acc_w_check
        $error("ptcalc_mac_rndsat: ACC_W too narrow for PROD_W and MAX_TERMS");
    end

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             restart;
    logic             beat;
    logic             burst_end;
    logic [OUT_W-1:0] core_pt;
    logic             core_sat;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds its payload stable until that edge; ready never waits on valid.
    assign prod_rdy = ap_rst_n && ((state == IDLE) || (state == ACCUM));
    assign pt_vld   = (state == OUT);
    assign beat     = prod_vld && prod_rdy;

    assign prod_ext  = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
    assign restart   = (state == IDLE) || prod_first;
    assign acc_next  = restart ? prod_ext : acc + prod_ext;
    assign cnt_next  = restart ? CNT_W'(1) : cnt + CNT_W'(1);
    assign burst_end = prod_last || (cnt_next == CNT_W'(MAX_TERMS));

    ptcalc_mac_rndsat_core #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_core (
        .acc (acc),
        .pt  (core_pt),
        .sat (core_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            pt_data   <= '0;
            pt_sat    <= 1'b0;
            pt_nterms <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc   <= acc_next;
                        cnt   <= cnt_next;
                        state <= burst_end ? ROUND : ACCUM;
                    end
                end
                ROUND: begin
                    pt_data   <= core_pt;
                    pt_sat    <= core_sat;
                    pt_nterms <= cnt;
                    state     <= OUT;
                end
                OUT: begin
                    if (pt_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptcalc_mac_rndsat.sv
// Randomized bench for ptcalc_mac_rndsat against a sum/floor/clip reference model.
// Build option: PTCALC_MAC_ROUND_EN switches the model to round half up.
module tb_ptcalc_mac_rndsat;

    localparam int PROD_W    = 38;
    localparam int MAX_TERMS = 8;
    localparam int SHIFT     = 12;
    localparam int OUT_W     = 16;
    localparam int CNT_W     = 4;
    localparam longint ONE   = 64'sd1 <<< SHIFT;
    localparam longint HI    = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint LO    = -(64'sd1 <<< (OUT_W - 1));
    localparam int EXP_W     = CNT_W + 1 + OUT_W;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              prod_vld;
    logic              prod_rdy;
    logic [PROD_W-1:0] prod_data;
    logic              prod_first;
    logic              prod_last;
    logic              pt_vld;
    logic              pt_rdy;
    logic [OUT_W-1:0]  pt_data;
    logic              pt_sat;
    logic [CNT_W-1:0]  pt_nterms;

    ptcalc_mac_rndsat dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_vld   (prod_vld),
        .prod_rdy   (prod_rdy),
        .prod_data  (prod_data),
        .prod_first (prod_first),
        .prod_last  (prod_last),
        .pt_vld     (pt_vld),
        .pt_rdy     (pt_rdy),
        .pt_data    (pt_data),
        .pt_sat     (pt_sat),
        .pt_nterms  (pt_nterms)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    initial forever @(posedge ap_clk) cyc++;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               end_q[$];
    bit               m_open = 0;
    longint           m_sum  = 0;
    int               m_n    = 0;

    function automatic logic [EXP_W-1:0] model_result(input longint sum, input int n);
        longint v;
        longint r;
        logic   s;
        logic [OUT_W-1:0] d;
        v = sum;
`ifdef PTCALC_MAC_ROUND_EN
        v = v + ONE / 2;
`endif
        r = (v - (((v % ONE) + ONE) % ONE)) / ONE;
        s = 1'b0;
        if (r > HI) begin r = HI; s = 1'b1; end
        else if (r < LO) begin r = LO; s = 1'b1; end
        d = r[OUT_W-1:0];
        return {CNT_W'(n), s, d};
    endfunction

    task automatic model_beat(input logic [PROD_W-1:0] d, input bit f, input bit l);
        if (!m_open || f) begin
            m_sum  = 0;
            m_n    = 0;
            m_open = 1;
        end
        m_sum = m_sum + longint'($signed(d));
        m_n++;
        if (l || m_n == MAX_TERMS) begin
            exp_q.push_back(model_result(m_sum, m_n));
            end_q.push_back(cyc);
            m_open = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_beat(input logic [PROD_W-1:0] d, input bit f, input bit l);
        int waited;
        bit ok;
        waited = 0;
        ok = 0;
        prod_vld   = 1'b1;
        prod_data  = d;
        prod_first = f;
        prod_last  = l;
        while (!ok && waited < 200) begin
            @(negedge ap_clk);
            if (prod_rdy) begin
                ok = 1;
                model_beat(d, f, l);
            end
            @(posedge ap_clk);
            #1;
            waited++;
        end
        if (!ok) check("beat_timeout", 64'd0, 64'd1);
        prod_vld   = 1'b0;
        prod_first = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        do begin
            @(negedge ap_clk);
            waited++;
        end while ((exp_q.size() != 0 || pt_vld) && waited < 300);
        if (waited >= 300) check("drain_timeout", 64'd0, 64'd1);
        @(posedge ap_clk);
        #1;
    endtask

    // ---------------- consumer / scoreboard ----------------
    int               stall_req = -1;
    int               wait_n    = 0;
    bit               holding   = 0;
    bit               hs_pending = 0;
    logic [EXP_W-1:0] held;

    initial begin
        logic [EXP_W-1:0] e;
        int t;
        pt_rdy = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                holding    = 0;
                hs_pending = 0;
                pt_rdy     = 1'b0;
            end else begin
                if (hs_pending) begin
                    check("idle_after_rdy", {62'd0, pt_vld, prod_rdy}, 64'd1);
                    hs_pending = 0;
                end
                if (pt_vld) begin
                    if (!holding) begin
                        holding = 1;
                        held = {pt_nterms, pt_sat, pt_data};
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 64'(held), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            t = end_q.pop_front();
                            check("pt_data",   64'(pt_data),   64'(e[OUT_W-1:0]));
                            check("pt_sat",    64'(pt_sat),    64'(e[OUT_W]));
                            check("pt_nterms", 64'(pt_nterms), 64'(e[EXP_W-1:OUT_W+1]));
                            check("latency",   64'(cyc - t),   64'd2);
                        end
                        wait_n = (stall_req >= 0) ? stall_req : int'($urandom_range(0, 3));
                    end else begin
                        check("out_stable", 64'({pt_nterms, pt_sat, pt_data}), 64'(held));
                    end
                    check("backpressure", 64'(prod_rdy), 64'd0);
                    if (wait_n == 0) begin
                        pt_rdy     = 1'b1;
                        holding    = 0;
                        hs_pending = 1;
                    end else begin
                        pt_rdy = 1'b0;
                        wait_n--;
                    end
                end else begin
                    pt_rdy = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [PROD_W-1:0] rand_data();
        logic [63:0] raw;
        case ($urandom_range(0, 3))
            0: begin
                raw = {$urandom, $urandom};
                return raw[PROD_W-1:0];
            end
            1: return PROD_W'(longint'($urandom_range(0, 400000)) - 200000);
            2: return PROD_W'((longint'($urandom_range(0, 40)) - 20) * ONE);
            default: return PROD_W'((longint'($urandom_range(0, 2000)) - 1000) * ONE + 2048);
        endcase
    endfunction

    initial begin
        ap_rst_n   = 1'b0;
        prod_vld   = 1'b0;
        prod_data  = '0;
        prod_first = 1'b0;
        prod_last  = 1'b0;
        #2;
        check("rst_pt_vld",    64'(pt_vld),    64'd0);
        check("rst_prod_rdy",  64'(prod_rdy),  64'd0);
        check("rst_pt_data",   64'(pt_data),   64'd0);
        check("rst_pt_sat",    64'(pt_sat),    64'd0);
        check("rst_pt_nterms", 64'(pt_nterms), 64'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // single 5.0 term, fractional sums, saturation both ways
        send_beat(PROD_W'(20480), 1, 1);
        wait_drain();
        send_beat(PROD_W'(4096), 1, 0);
        send_beat(PROD_W'(8192), 0, 0);
        send_beat(PROD_W'(-2048), 0, 1);
        wait_drain();
        send_beat(PROD_W'(-4096), 1, 0);
        send_beat(PROD_W'(-6144), 0, 1);
        wait_drain();
        send_beat(PROD_W'((64'sd1 <<< 37) - 1), 1, 1);
        wait_drain();
        send_beat(PROD_W'(-(64'sd1 <<< 37)), 1, 1);
        wait_drain();

        // held output with 5 cycles of backpressure
        stall_req = 5;
        send_beat(PROD_W'(12288), 1, 1);
        wait_drain();

        // forced end at MAX_TERMS; ninth beat waits and opens a new burst
        stall_req = 3;
        for (int i = 0; i < 9; i++) send_beat(PROD_W'(4096), i == 0, 0);
        send_beat(PROD_W'(4096), 0, 1);
        wait_drain();
        stall_req = -1;

        // restart mid-burst
        send_beat(PROD_W'(4096), 1, 0);
        send_beat(PROD_W'(8192), 1, 1);
        wait_drain();

        // reset during ACCUM
        send_beat(PROD_W'(4096), 1, 0);
        send_beat(PROD_W'(4096), 0, 0);
        ap_rst_n = 1'b0;
        m_open   = 0;
        #1;
        check("arst_prod_rdy", 64'(prod_rdy), 64'd0);
        check("arst_pt_vld",   64'(pt_vld),   64'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        send_beat(PROD_W'(8192), 0, 1);
        wait_drain();

        // reset while a result is held in OUT
        stall_req = 1000;
        send_beat(PROD_W'(20480), 1, 1);
        begin
            int w;
            w = 0;
            do begin
                @(negedge ap_clk);
                w++;
            end while (!pt_vld && w < 20);
            if (w >= 20) check("out_timeout", 64'd0, 64'd1);
        end
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("orst_pt_vld",  64'(pt_vld),  64'd0);
        check("orst_pt_data", 64'(pt_data), 64'd0);
        stall_req = -1;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // random bursts
        for (int b = 0; b < 60; b++) begin
            int len;
            len = int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) begin
                bit f;
                f = (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                send_beat(rand_data(), f, i == len - 1);
                repeat ($urandom_range(0, 1)) @(posedge ap_clk);
                #1;
            end
            repeat ($urandom_range(0, 2)) @(posedge ap_clk);
            #1;
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
